// File: rtl/axi_strb_mem_pkg.sv
// Shared constants for the strobed simple-dual-port memory
// behind the AXI-FULL slave.
package axi_strb_mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 256;

    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

    localparam bit MODE_WR_FIRST = 1'b1;
    localparam bit MODE_RD_FIRST = 1'b0;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axi_strb_mem_rd_pipe.sv
// Read-return delay line carrying {vld, err, data}.
// Every stage is cleared by reset so in-flight reads are dropped.
module mem_rd_pipe #(
    parameter int W      = 34,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/axi_strb_mem.sv
// Simple-dual-port memory with byte strobes, 1/2-cycle read latency,
// defined read-during-write behaviour and range checking.
module axi_strb_mem
    import axi_strb_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RD_LAT   = RD_LAT_1,
    parameter bit WR_FIRST = MODE_WR_FIRST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic [DATA_W-1:0]   wr_dat,
    output logic                wr_err,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_dat_vld,
    output logic [DATA_W-1:0]   rd_dat,
    output logic                rd_err
);

    localparam int STRB_W = strb_w(DATA_W);
    localparam int PIPE_W = DATA_W + 2;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    if (RD_LAT != RD_LAT_1 && RD_LAT != RD_LAT_2) begin : g_bad_lat
        $error("axi_strb_mem: RD_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("axi_strb_mem: DATA_W must be a multiple of 8");
    end

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] nw,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = nw[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok;
    logic              rd_ok;
    logic              collide;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data;
    logic [PIPE_W-1:0] pipe_d;
    logic [PIPE_W-1:0] pipe_q;
    logic [DATA_W-1:0] hold_dat;
    logic              hold_err;

    assign wr_ok   = {1'b0, wr_addr} < LIMIT;
    assign rd_ok   = {1'b0, rd_addr} < LIMIT;
    assign collide = wr_en & rd_en & wr_ok & (wr_addr == rd_addr);

    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[rd_addr];
        end
        rd_data = rd_word;
        if (WR_FIRST && collide) begin
            rd_data = merge(rd_word, wr_dat, wr_strb);
        end
    end

    assign pipe_d = {rd_en, rd_en & ~rd_ok, rd_en ? rd_data : '0};

    mem_rd_pipe #(
        .W      (PIPE_W),
        .STAGES (RD_LAT)
    ) u_rd_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pipe_d),
        .q     (pipe_q)
    );

    // Storage is never reset; the write is gated so none lands in reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en && wr_ok) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err   <= 1'b0;
            hold_dat <= '0;
            hold_err <= 1'b0;
        end else begin
            wr_err <= wr_en & ~wr_ok;
            if (pipe_q[PIPE_W-1]) begin
                hold_dat <= pipe_q[DATA_W-1:0];
                hold_err <= pipe_q[DATA_W];
            end
        end
    end

    assign rd_dat_vld = pipe_q[PIPE_W-1];
    assign rd_dat     = rd_dat_vld ? pipe_q[DATA_W-1:0] : hold_dat;
    assign rd_err     = rd_dat_vld ? pipe_q[DATA_W] : hold_err;

endmodule

// File: tb/tb_axi_strb_mem.sv
// Scoreboard bench: dut_a is RD_LAT=1/WR_FIRST=1, dut_b is RD_LAT=2/WR_FIRST=0,
// both DEPTH=200 and driven by the same stimulus.
module tb_axi_strb_mem;

    localparam int DEP = 200;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        we;
        logic [7:0]  wa;
        logic [3:0]  ws;
        logic [31:0] wd;
        logic        re;
        logic [7:0]  ra;
        logic        ka;
        logic [31:0] va;
        logic        ea;
        logic        kb;
        logic [31:0] vb;
        logic        eb;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [3:0]  wr_strb = '0;
    logic [31:0] wr_dat = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;

    logic        wr_err_a, vld_a, err_a;
    logic [31:0] dat_a;
    logic        wr_err_b, vld_b, err_b;
    logic [31:0] dat_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [31:0] model [256];
    exp_t        qa [$];
    exp_t        qb [$];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    logic        lerr_a = 1'b0;
    logic        lerr_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_strb_mem #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(DEP), .RD_LAT(1), .WR_FIRST(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
        .wr_dat(wr_dat), .wr_err(wr_err_a),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_dat_vld(vld_a), .rd_dat(dat_a), .rd_err(err_a)
    );

    axi_strb_mem #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(DEP), .RD_LAT(2), .WR_FIRST(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
        .wr_dat(wr_dat), .wr_err(wr_err_b),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_dat_vld(vld_b), .rd_dat(dat_b), .rd_err(err_b)
    );

    function automatic logic [31:0] lane_mix(
        input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    function automatic step_t mk(
        input logic we, input logic [7:0] wa, input logic [3:0] ws,
        input logic [31:0] wd, input logic re, input logic [7:0] ra
    );
        step_t s;
        s.rst = 1'b0; s.we = we; s.wa = wa; s.ws = ws; s.wd = wd;
        s.re = re; s.ra = ra;
        s.ka = 1'b0; s.va = '0; s.ea = 1'b0;
        s.kb = 1'b0; s.vb = '0; s.eb = 1'b0;
        return s;
    endfunction

    // Drive one cycle of stimulus at a negedge, update the model and
    // return at the next negedge where outputs are sampled.
    task automatic issue(input step_t s);
        exp_t        e;
        logic [31:0] old;
        rst_n   = !s.rst;
        wr_en   = s.we;
        wr_addr = s.wa;
        wr_strb = s.ws;
        wr_dat  = s.wd;
        rd_en   = s.re;
        rd_addr = s.ra;
        if (s.rst) begin
            qa.delete();
            qb.delete();
            last_a = '0; last_b = '0;
            lerr_a = 1'b0; lerr_b = 1'b0;
        end else begin
            if (s.re) begin
                e.err = (int'(s.ra) >= DEP);
                old   = e.err ? 32'h0 : model[s.ra];
                e.cyc = cyc + 1;
                e.dat = (!e.err && s.we && s.wa == s.ra) ?
                        lane_mix(old, s.wd, s.ws) : old;
                qa.push_back(e);
                e.cyc = cyc + 2;
                e.dat = old;
                qb.push_back(e);
            end
            if (s.we && int'(s.wa) < DEP) begin
                model[s.wa] = lane_mix(model[s.wa], s.wd, s.ws);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({vld_a, err_a, wr_err_a, dat_a} !== 35'h0) begin
            errors++;
            $display("FAIL reset_a: vld %b err %b wr_err %b dat %h, want all 0",
                     vld_a, err_a, wr_err_a, dat_a);
        end
        checks++;
        if ({vld_b, err_b, wr_err_b, dat_b} !== 35'h0) begin
            errors++;
            $display("FAIL reset_b: vld %b err %b wr_err %b dat %h, want all 0",
                     vld_b, err_b, wr_err_b, dat_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        step_t s;
        step_t st [$];
        st.push_back(mk(1, 5, 4'hF, 32'hDEADBEEF, 0, 0));
        s = mk(0, 0, 0, 0, 1, 5); s.ka = 1; s.va = 32'hDEADBEEF;
        st.push_back(s);
        s = mk(1, 5, 4'h5, 32'h11223344, 0, 0); s.kb = 1; s.vb = 32'hDEADBEEF;
        st.push_back(s);
        s = mk(0, 0, 0, 0, 1, 5); s.ka = 1; s.va = 32'hDE22BE44;
        st.push_back(s);
        s = mk(0, 0, 0, 0, 0, 0); s.kb = 1; s.vb = 32'hDE22BE44;
        st.push_back(s);
        repeat (2) st.push_back(mk(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            exp_t e;
            issue(st[i]);
            if (st[i].ka) begin
                checks++;
                if (vld_a !== 1'b1 || dat_a !== st[i].va || err_a !== st[i].ea) begin
                    errors++;
                    $display("FAIL wr_rd[%0d] a: vld %b err %b dat %h, want 1 %b %h",
                             i, vld_a, err_a, dat_a, st[i].ea, st[i].va);
                end
            end
            if (st[i].kb) begin
                checks++;
                if (vld_b !== 1'b1 || dat_b !== st[i].vb || err_b !== st[i].eb) begin
                    errors++;
                    $display("FAIL wr_rd[%0d] b: vld %b err %b dat %h, want 1 %b %h",
                             i, vld_b, err_b, dat_b, st[i].eb, st[i].vb);
                end
            end
            checks++;
            if (vld_a === 1'b1) begin
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL wr_rd[%0d] a: vld 1, want no read in flight", i);
                end else begin
                    e = qa.pop_front();
                    if (cyc != e.cyc || err_a !== e.err || dat_a !== e.dat) begin
                        errors++;
                        $display("FAIL wr_rd[%0d] a: cyc %0d err %b dat %h, want %0d %b %h",
                                 i, cyc, err_a, dat_a, e.cyc, e.err, e.dat);
                    end
                    last_a = e.dat; lerr_a = e.err;
                end
            end else if (dat_a !== last_a || err_a !== lerr_a) begin
                errors++;
                $display("FAIL wr_rd[%0d] a hold: dat %h err %b, want %h %b",
                         i, dat_a, err_a, last_a, lerr_a);
            end
            checks++;
            if (vld_b === 1'b1) begin
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL wr_rd[%0d] b: vld 1, want no read in flight", i);
                end else begin
                    e = qb.pop_front();
                    if (cyc != e.cyc || err_b !== e.err || dat_b !== e.dat) begin
                        errors++;
                        $display("FAIL wr_rd[%0d] b: cyc %0d err %b dat %h, want %0d %b %h",
                                 i, cyc, err_b, dat_b, e.cyc, e.err, e.dat);
                    end
                    last_b = e.dat; lerr_b = e.err;
                end
            end else if (dat_b !== last_b || err_b !== lerr_b) begin
                errors++;
                $display("FAIL wr_rd[%0d] b hold: dat %h err %b, want %h %b",
                         i, dat_b, err_b, last_b, lerr_b);
            end
        end
        checks++;
        if (qa.size() + qb.size() != 0) begin
            errors++;
            $display("FAIL wr_rd drain: %0d/%0d reads pending, want 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_collision();
        step_t s;
        step_t st [$];
        st.push_back(mk(1, 9, 4'hF, 32'hAAAAAAAA, 0, 0));
        s = mk(1, 9, 4'h3, 32'h55555555, 1, 9); s.ka = 1; s.va = 32'hAAAA5555;
        st.push_back(s);
        s = mk(0, 0, 0, 0, 1, 9); s.ka = 1; s.va = 32'hAAAA5555;
        s.kb = 1; s.vb = 32'hAAAAAAAA;
        st.push_back(s);
        s = mk(0, 0, 0, 0, 0, 0); s.kb = 1; s.vb = 32'hAAAA5555;
        st.push_back(s);
        repeat (2) st.push_back(mk(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            exp_t e;
            issue(st[i]);
            if (st[i].ka) begin
                checks++;
                if (vld_a !== 1'b1 || dat_a !== st[i].va || err_a !== st[i].ea) begin
                    errors++;
                    $display("FAIL coll[%0d] a: vld %b err %b dat %h, want 1 %b %h",
                             i, vld_a, err_a, dat_a, st[i].ea, st[i].va);
                end
            end
            if (st[i].kb) begin
                checks++;
                if (vld_b !== 1'b1 || dat_b !== st[i].vb || err_b !== st[i].eb) begin
                    errors++;
                    $display("FAIL coll[%0d] b: vld %b err %b dat %h, want 1 %b %h",
                             i, vld_b, err_b, dat_b, st[i].eb, st[i].vb);
                end
            end
            checks++;
            if (vld_a === 1'b1) begin
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL coll[%0d] a: vld 1, want no read in flight", i);
                end else begin
                    e = qa.pop_front();
                    if (cyc != e.cyc || err_a !== e.err || dat_a !== e.dat) begin
                        errors++;
                        $display("FAIL coll[%0d] a: cyc %0d err %b dat %h, want %0d %b %h",
                                 i, cyc, err_a, dat_a, e.cyc, e.err, e.dat);
                    end
                    last_a = e.dat; lerr_a = e.err;
                end
            end else if (dat_a !== last_a || err_a !== lerr_a) begin
                errors++;
                $display("FAIL coll[%0d] a hold: dat %h err %b, want %h %b",
                         i, dat_a, err_a, last_a, lerr_a);
            end
            checks++;
            if (vld_b === 1'b1) begin
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL coll[%0d] b: vld 1, want no read in flight", i);
                end else begin
                    e = qb.pop_front();
                    if (cyc != e.cyc || err_b !== e.err || dat_b !== e.dat) begin
                        errors++;
                        $display("FAIL coll[%0d] b: cyc %0d err %b dat %h, want %0d %b %h",
                                 i, cyc, err_b, dat_b, e.cyc, e.err, e.dat);
                    end
                    last_b = e.dat; lerr_b = e.err;
                end
            end else if (dat_b !== last_b || err_b !== lerr_b) begin
                errors++;
                $display("FAIL coll[%0d] b hold: dat %h err %b, want %h %b",
                         i, dat_b, err_b, last_b, lerr_b);
            end
        end
        checks++;
        if (qa.size() + qb.size() != 0) begin
            errors++;
            $display("FAIL coll drain: %0d/%0d reads pending, want 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        step_t st [$];
        for (int k = 0; k < 8; k++) begin
            st.push_back(mk(1, 8'(k), 4'hF, 32'(k), 0, 0));
        end
        for (int k = 0; k < 9; k++) begin
            s = (k < 8) ? mk(0, 0, 0, 0, 1, 8'(k)) : mk(0, 0, 0, 0, 0, 0);
            if (k < 8) begin s.ka = 1; s.va = 32'(k); end
            if (k > 0) begin s.kb = 1; s.vb = 32'(k - 1); end
            st.push_back(s);
        end
        repeat (3) st.push_back(mk(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            exp_t e;
            issue(st[i]);
            if (st[i].ka) begin
                checks++;
                if (vld_a !== 1'b1 || dat_a !== st[i].va || err_a !== st[i].ea) begin
                    errors++;
                    $display("FAIL b2b[%0d] a: vld %b err %b dat %h, want 1 %b %h",
                             i, vld_a, err_a, dat_a, st[i].ea, st[i].va);
                end
            end
            if (st[i].kb) begin
                checks++;
                if (vld_b !== 1'b1 || dat_b !== st[i].vb || err_b !== st[i].eb) begin
                    errors++;
                    $display("FAIL b2b[%0d] b: vld %b err %b dat %h, want 1 %b %h",
                             i, vld_b, err_b, dat_b, st[i].eb, st[i].vb);
                end
            end
            checks++;
            if (vld_a === 1'b1) begin
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL b2b[%0d] a: vld 1, want no read in flight", i);
                end else begin
                    e = qa.pop_front();
                    if (cyc != e.cyc || err_a !== e.err || dat_a !== e.dat) begin
                        errors++;
                        $display("FAIL b2b[%0d] a: cyc %0d err %b dat %h, want %0d %b %h",
                                 i, cyc, err_a, dat_a, e.cyc, e.err, e.dat);
                    end
                    last_a = e.dat; lerr_a = e.err;
                end
            end else if (dat_a !== last_a || err_a !== lerr_a) begin
                errors++;
                $display("FAIL b2b[%0d] a hold: dat %h err %b, want %h %b",
                         i, dat_a, err_a, last_a, lerr_a);
            end
            checks++;
            if (vld_b === 1'b1) begin
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b[%0d] b: vld 1, want no read in flight", i);
                end else begin
                    e = qb.pop_front();
                    if (cyc != e.cyc || err_b !== e.err || dat_b !== e.dat) begin
                        errors++;
                        $display("FAIL b2b[%0d] b: cyc %0d err %b dat %h, want %0d %b %h",
                                 i, cyc, err_b, dat_b, e.cyc, e.err, e.dat);
                    end
                    last_b = e.dat; lerr_b = e.err;
                end
            end else if (dat_b !== last_b || err_b !== lerr_b) begin
                errors++;
                $display("FAIL b2b[%0d] b hold: dat %h err %b, want %h %b",
                         i, dat_b, err_b, last_b, lerr_b);
            end
        end
        checks++;
        if (qa.size() + qb.size() != 0) begin
            errors++;
            $display("FAIL b2b drain: %0d/%0d reads pending, want 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_out_of_range();
        step_t s;
        step_t st [$];
        logic  werr;
        st.push_back(mk(1, 199, 4'hF, 32'hCAFEF00D, 0, 0));
        st.push_back(mk(1, 250, 4'hF, 32'h12345678, 0, 0));
        s = mk(0, 0, 0, 0, 1, 250); s.ka = 1; s.va = 0; s.ea = 1;
        st.push_back(s);
        s = mk(0, 0, 0, 0, 1, 199); s.ka = 1; s.va = 32'hCAFEF00D;
        s.kb = 1; s.vb = 0; s.eb = 1;
        st.push_back(s);
        s = mk(1, 200, 4'hF, 32'hFFFFFFFF, 0, 0); s.kb = 1; s.vb = 32'hCAFEF00D;
        st.push_back(s);
        s = mk(0, 0, 0, 0, 1, 200); s.ka = 1; s.va = 0; s.ea = 1;
        st.push_back(s);
        s = mk(0, 0, 0, 0, 0, 0); s.kb = 1; s.vb = 0; s.eb = 1;
        st.push_back(s);
        repeat (2) st.push_back(mk(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            exp_t e;
            issue(st[i]);
            werr = st[i].we && int'(st[i].wa) >= DEP;
            checks++;
            if (wr_err_a !== werr || wr_err_b !== werr) begin
                errors++;
                $display("FAIL oor[%0d] wr_err: a %b b %b, want %b",
                         i, wr_err_a, wr_err_b, werr);
            end
            if (st[i].ka) begin
                checks++;
                if (vld_a !== 1'b1 || dat_a !== st[i].va || err_a !== st[i].ea) begin
                    errors++;
                    $display("FAIL oor[%0d] a: vld %b err %b dat %h, want 1 %b %h",
                             i, vld_a, err_a, dat_a, st[i].ea, st[i].va);
                end
            end
            if (st[i].kb) begin
                checks++;
                if (vld_b !== 1'b1 || dat_b !== st[i].vb || err_b !== st[i].eb) begin
                    errors++;
                    $display("FAIL oor[%0d] b: vld %b err %b dat %h, want 1 %b %h",
                             i, vld_b, err_b, dat_b, st[i].eb, st[i].vb);
                end
            end
            checks++;
            if (vld_a === 1'b1) begin
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL oor[%0d] a: vld 1, want no read in flight", i);
                end else begin
                    e = qa.pop_front();
                    if (cyc != e.cyc || err_a !== e.err || dat_a !== e.dat) begin
                        errors++;
                        $display("FAIL oor[%0d] a: cyc %0d err %b dat %h, want %0d %b %h",
                                 i, cyc, err_a, dat_a, e.cyc, e.err, e.dat);
                    end
                    last_a = e.dat; lerr_a = e.err;
                end
            end else if (dat_a !== last_a || err_a !== lerr_a) begin
                errors++;
                $display("FAIL oor[%0d] a hold: dat %h err %b, want %h %b",
                         i, dat_a, err_a, last_a, lerr_a);
            end
            checks++;
            if (vld_b === 1'b1) begin
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL oor[%0d] b: vld 1, want no read in flight", i);
                end else begin
                    e = qb.pop_front();
                    if (cyc != e.cyc || err_b !== e.err || dat_b !== e.dat) begin
                        errors++;
                        $display("FAIL oor[%0d] b: cyc %0d err %b dat %h, want %0d %b %h",
                                 i, cyc, err_b, dat_b, e.cyc, e.err, e.dat);
                    end
                    last_b = e.dat; lerr_b = e.err;
                end
            end else if (dat_b !== last_b || err_b !== lerr_b) begin
                errors++;
                $display("FAIL oor[%0d] b hold: dat %h err %b, want %h %b",
                         i, dat_b, err_b, last_b, lerr_b);
            end
        end
        checks++;
        if (qa.size() + qb.size() != 0) begin
            errors++;
            $display("FAIL oor drain: %0d/%0d reads pending, want 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_reset_burst();
        step_t s;
        step_t st [$];
        s = mk(0, 0, 0, 0, 1, 0); s.ka = 1; s.va = 0;
        st.push_back(s);
        s = mk(0, 0, 0, 0, 1, 1); s.ka = 1; s.va = 1; s.kb = 1; s.vb = 0;
        st.push_back(s);
        s = mk(1, 0, 4'hF, 32'hFFFFFFFF, 1, 2); s.rst = 1;
        st.push_back(s);
        repeat (2) st.push_back(mk(0, 0, 0, 0, 0, 0));
        s = mk(0, 0, 0, 0, 1, 0); s.ka = 1; s.va = 0;
        st.push_back(s);
        s = mk(0, 0, 0, 0, 1, 9); s.ka = 1; s.va = 32'hAAAA5555; s.kb = 1; s.vb = 0;
        st.push_back(s);
        s = mk(0, 0, 0, 0, 0, 0); s.kb = 1; s.vb = 32'hAAAA5555;
        st.push_back(s);
        repeat (2) st.push_back(mk(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            exp_t e;
            issue(st[i]);
            if (st[i].ka) begin
                checks++;
                if (vld_a !== 1'b1 || dat_a !== st[i].va || err_a !== st[i].ea) begin
                    errors++;
                    $display("FAIL rst_burst[%0d] a: vld %b err %b dat %h, want 1 %b %h",
                             i, vld_a, err_a, dat_a, st[i].ea, st[i].va);
                end
            end
            if (st[i].kb) begin
                checks++;
                if (vld_b !== 1'b1 || dat_b !== st[i].vb || err_b !== st[i].eb) begin
                    errors++;
                    $display("FAIL rst_burst[%0d] b: vld %b err %b dat %h, want 1 %b %h",
                             i, vld_b, err_b, dat_b, st[i].eb, st[i].vb);
                end
            end
            checks++;
            if (vld_a === 1'b1) begin
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL rst_burst[%0d] a: vld 1, want no read in flight", i);
                end else begin
                    e = qa.pop_front();
                    if (cyc != e.cyc || err_a !== e.err || dat_a !== e.dat) begin
                        errors++;
                        $display("FAIL rst_burst[%0d] a: cyc %0d err %b dat %h, want %0d %b %h",
                                 i, cyc, err_a, dat_a, e.cyc, e.err, e.dat);
                    end
                    last_a = e.dat; lerr_a = e.err;
                end
            end else if (dat_a !== last_a || err_a !== lerr_a) begin
                errors++;
                $display("FAIL rst_burst[%0d] a hold: dat %h err %b, want %h %b",
                         i, dat_a, err_a, last_a, lerr_a);
            end
            checks++;
            if (vld_b === 1'b1) begin
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL rst_burst[%0d] b: vld 1, want no read in flight", i);
                end else begin
                    e = qb.pop_front();
                    if (cyc != e.cyc || err_b !== e.err || dat_b !== e.dat) begin
                        errors++;
                        $display("FAIL rst_burst[%0d] b: cyc %0d err %b dat %h, want %0d %b %h",
                                 i, cyc, err_b, dat_b, e.cyc, e.err, e.dat);
                    end
                    last_b = e.dat; lerr_b = e.err;
                end
            end else if (dat_b !== last_b || err_b !== lerr_b) begin
                errors++;
                $display("FAIL rst_burst[%0d] b hold: dat %h err %b, want %h %b",
                         i, dat_b, err_b, last_b, lerr_b);
            end
        end
        checks++;
        if (qa.size() + qb.size() != 0) begin
            errors++;
            $display("FAIL rst_burst drain: %0d/%0d reads pending, want 0/0",
                     qa.size(), qb.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_reset_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
